fmul_share: RTL and testbench

Sequencer that time-shares one `fmul` instance between two requesters, e.g. the FPU issue slot and the divide/sqrt microsequencer. Each requester offers an operand pair with a valid/ready handshake. A round-robin arbiter grants one request at a time; the block registers the operands into `fmul`, waits a parameterised latency, and returns `y`/`ovf` tagged with the requester id. Per-requester sticky overflow flags collect `ovf` for the exception/status logic.

---
 rtl/fmul_share.sv | 174 +++++++++++++++++
 tb/tb_fmul_share.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_share.sv
// Time-shares one single-precision multiplier between two requesters.
// A round-robin grant feeds registered operands to fmul; results return tagged by requester.

module fmul (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] y_o,
    output logic        ovf_o
);
    logic        sign;
    logic [7:0]  ea, eb;
    logic [23:0] ma, mb, mant;
    logic [47:0] prod;
    logic        hi, rnd, stk;
    logic [24:0] mant_r;
    logic [10:0] exp_b;
    logic        a_nan, b_nan;

    // Denormal inputs flush to zero, overflow saturates to infinity, rounding is nearest-even.
    always_comb begin
        sign   = a_i[31] ^ b_i[31];
        ea     = a_i[30:23];
        eb     = b_i[30:23];
        ma     = {1'b1, a_i[22:0]};
        mb     = {1'b1, b_i[22:0]};
        a_nan  = (ea == 8'hFF) && (a_i[22:0] != 23'd0);
        b_nan  = (eb == 8'hFF) && (b_i[22:0] != 23'd0);
        prod   = {24'd0, ma} * {24'd0, mb};
        hi     = prod[47];
        mant   = hi ? prod[47:24] : prod[46:23];
        rnd    = hi ? prod[23] : prod[22];
        stk    = hi ? (|prod[22:0]) : (|prod[21:0]);
        mant_r = {1'b0, mant} + {24'd0, rnd & (stk | mant[0])};
        exp_b  = {3'b000, ea} + {3'b000, eb} + {10'd0, hi} + {10'd0, mant_r[24]};
        y_o    = {sign, 31'd0};
        ovf_o  = 1'b0;
        if (ea == 8'hFF || eb == 8'hFF) begin
            if (a_nan || b_nan || ea == 8'h00 || eb == 8'h00)
                y_o = 32'h7FC0_0000;
            else
                y_o = {sign, 8'hFF, 23'd0};
        end else if (ea == 8'h00 || eb == 8'h00) begin
            y_o = {sign, 31'd0};
        end else if (exp_b >= 11'd382) begin
            y_o   = {sign, 8'hFF, 23'd0};
            ovf_o = 1'b1;
        end else if (exp_b <= 11'd127) begin
            y_o = {sign, 31'd0};
        end else begin
            y_o = {sign, exp_b[7:0] - 8'd127, mant_r[24] ? mant_r[23:1] : mant_r[22:0]};
        end
    end
endmodule

module fmul_share #(
    parameter int unsigned LAT = 1  // legal range 1..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_x1,
    input  logic [63:0] req_x2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_y,
    output logic        rsp_ovf,
    output logic [1:0]  ovf_sticky,
    input  logic [1:0]  ovf_clr,
    output logic        busy,
    output logic [1:0]  state_dbg_o
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // a requester holds valid and operands stable until it sees ready.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        last_q;
    logic        id_q;
    logic [31:0] a_q, b_q, y_q;
    logic        ovf_q;
    logic [1:0]  sticky_q;

    logic        grant_d;
    logic        accept_d;
    logic [1:0]  set_d;
    logic [1:0]  sticky_d;
    logic [31:0] f_y;
    logic        f_ovf;

    fmul u_fmul (
        .a_i   (a_q),
        .b_i   (b_q),
        .y_o   (f_y),
        .ovf_o (f_ovf)
    );

    always_comb begin
        grant_d = ~last_q;
        if (req_valid == 2'b01)
            grant_d = 1'b0;
        else if (req_valid == 2'b10)
            grant_d = 1'b1;
    end

    assign req_ready = (state_q == S_IDLE) ? (grant_d ? 2'b10 : 2'b01) : 2'b00;
    assign accept_d  = |(req_valid & req_ready);

    // Set beats clear so an overflow landing in the same cycle as a clear is kept.
    always_comb begin
        set_d = 2'b00;
        if (state_q == S_RESP && rsp_ready && ovf_q)
            set_d = id_q ? 2'b10 : 2'b01;
        sticky_d = (sticky_q & ~ovf_clr) | set_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            last_q   <= 1'b1;
            id_q     <= 1'b0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            y_q      <= 32'd0;
            ovf_q    <= 1'b0;
            sticky_q <= 2'b00;
        end else begin
            sticky_q <= sticky_d;
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        a_q     <= grant_d ? req_x1[63:32] : req_x1[31:0];
                        b_q     <= grant_d ? req_x2[63:32] : req_x2[31:0];
                        id_q    <= grant_d;
                        last_q  <= grant_d;
                        cnt_q   <= LAT_M1;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        y_q     <= f_y;
                        ovf_q   <= f_ovf;
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_id      = id_q;
    assign rsp_y       = y_q;
    assign rsp_ovf     = ovf_q;
    assign ovf_sticky  = sticky_q;
    assign busy        = (state_q != S_IDLE);
    assign state_dbg_o = state_q;
endmodule

// File: tb/tb_fmul_share.sv
// Directed bench for fmul_share: scoreboard queue checked by a response monitor,
// plus a LAT=4 instance for latency and mid-operation reset.

module tb_fmul_share;
    logic        clk;
    logic        rst;
    logic [1:0]  req_valid, req_ready;
    logic [63:0] req_x1, req_x2;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_ovf, busy;
    logic [31:0] rsp_y;
    logic [1:0]  ovf_sticky, ovf_clr, state_dbg;

    logic        r4_rst;
    logic [1:0]  r4_valid, r4_ready;
    logic [63:0] r4_x1, r4_x2;
    logic        r4_rsp_valid, r4_rsp_ready, r4_rsp_id, r4_rsp_ovf, r4_busy;
    logic [31:0] r4_rsp_y;
    logic [1:0]  r4_sticky, r4_clr, r4_state;

    int checks;
    int failures;
    logic [33:0] exp_q[$];  // {id, ovf, y}

    fmul_share #(.LAT(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_x1(req_x1), .req_x2(req_x2), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_ovf(rsp_ovf), .ovf_sticky(ovf_sticky),
        .ovf_clr(ovf_clr), .busy(busy), .state_dbg_o(state_dbg)
    );

    fmul_share #(.LAT(4)) dut4 (
        .clk(clk), .rst(r4_rst), .req_valid(r4_valid), .req_ready(r4_ready),
        .req_x1(r4_x1), .req_x2(r4_x2), .rsp_valid(r4_rsp_valid), .rsp_ready(r4_rsp_ready),
        .rsp_id(r4_rsp_id), .rsp_y(r4_rsp_y), .rsp_ovf(r4_rsp_ovf), .ovf_sticky(r4_sticky),
        .ovf_clr(r4_clr), .busy(r4_busy), .state_dbg_o(r4_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // Driver: raise valid for requester id and hold until the grant edge.
    task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [33:0] exp);
        int n;
        req_valid[id]      = 1'b1;
        req_x1[32*id +: 32] = a;
        req_x2[32*id +: 32] = b;
        exp_q.push_back(exp);
        n = 0;
        @(negedge clk);
        while (!req_ready[id] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[id]) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout id=%0d got=no_ready required=ready", id);
        end
        tick();
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || rsp_valid || exp_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout got=busy required=idle");
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [33:0] e;
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected got=%h required=none", {rsp_id, rsp_ovf, rsp_y});
            end else begin
                e = exp_q.pop_front();
                check("rsp", {30'd0, rsp_id, rsp_ovf, rsp_y}, {30'd0, e});
            end
        end
    end

    initial begin
        int n;
        checks = 0;
        failures = 0;
        rst = 1'b1; r4_rst = 1'b1;
        req_valid = 2'b00; req_x1 = 64'd0; req_x2 = 64'd0; rsp_ready = 1'b1; ovf_clr = 2'b00;
        r4_valid = 2'b00; r4_x1 = 64'd0; r4_x2 = 64'd0; r4_rsp_ready = 1'b1; r4_clr = 2'b00;
        repeat (3) tick();
        rst = 1'b0; r4_rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ready", req_ready, 2'b01);
        check("rst_rsp", {rsp_valid, rsp_id, rsp_ovf, rsp_y}, 35'd0);
        check("rst_sticky", ovf_sticky, 2'b00);
        check("rst_busy", busy, 1'b0);
        tick();

        // Single op, LAT=1: accept cycle 0, RESP cycle 2
        req_valid = 2'b01; req_x1[31:0] = 32'h3F80_0000; req_x2[31:0] = 32'h4000_0000;
        exp_q.push_back({1'b0, 1'b0, 32'h4000_0000});
        @(negedge clk);
        check("single_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        check("single_c1", {busy, rsp_valid}, 2'b10);
        tick();
        @(negedge clk);
        check("single_c2", {busy, rsp_valid}, 2'b11);
        tick();
        @(negedge clk);
        check("single_c3_busy", busy, 1'b0);
        check("single_sticky", ovf_sticky, 2'b00);

        // Overflow on requester 1, sticky set then cleared
        tick();
        issue(1, 32'h7F00_0000, 32'h4000_0000, {1'b1, 1'b1, 32'h7F80_0000});
        wait_idle();
        check("ovf_sticky_set", ovf_sticky, 2'b10);
        tick();
        ovf_clr = 2'b10;
        tick();
        ovf_clr = 2'b00;
        @(negedge clk);
        check("ovf_sticky_clr", ovf_sticky, 2'b00);

        // Contention: grant order 0,1,0,1
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        req_x1 = {32'hC000_0000, 32'h4040_0000};
        req_x2 = {32'h3F00_0000, 32'h4000_0000};
        for (int k = 0; k < 4; k++)
            exp_q.push_back((k % 2 == 0) ? {1'b0, 1'b0, 32'h40C0_0000} : {1'b1, 1'b0, 32'hBF80_0000});
        for (int k = 0; k < 4; k++) begin
            n = 0;
            @(negedge clk);
            while (req_ready == 2'b00 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("grant_order", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
        end
        req_valid = 2'b00;
        wait_idle();

        // Back-pressure with requester 1 pending
        tick();
        rsp_ready = 1'b0;
        issue(0, 32'h4040_0000, 32'h4000_0000, {1'b0, 1'b0, 32'h40C0_0000});
        req_valid[1] = 1'b1; req_x1[63:32] = 32'hC000_0000; req_x2[63:32] = 32'h3F00_0000;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_rsp", {rsp_valid, rsp_id, rsp_ovf, rsp_y}, {1'b1, 1'b0, 1'b0, 32'h40C0_0000});
            check("bp_ready", req_ready, 2'b00);
        end
        tick();
        rsp_ready = 1'b1;
        exp_q.push_back({1'b1, 1'b0, 32'hBF80_0000});
        @(negedge clk);
        check("bp_hs_ready", req_ready, 2'b00);
        tick();
        @(negedge clk);
        check("bp_next_ready", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        check("bp_next_busy", busy, 1'b1);
        wait_idle();

        // Sticky set/clear collision on requester 0
        do_reset();
        rsp_ready = 1'b0;
        issue(0, 32'h7F00_0000, 32'h4000_0000, {1'b0, 1'b1, 32'h7F80_0000});
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        tick();
        rsp_ready = 1'b1;
        ovf_clr = 2'b01;
        tick();
        ovf_clr = 2'b00;
        @(negedge clk);
        check("collide_sticky", ovf_sticky, 2'b01);
        tick();
        ovf_clr = 2'b01;
        tick();
        ovf_clr = 2'b00;
        @(negedge clk);
        check("collide_clr", ovf_sticky, 2'b00);

        // LAT=4 latency: accept cycle 0, RESP cycle 5
        tick();
        r4_valid = 2'b01; r4_x1[31:0] = 32'h3F80_0000; r4_x2[31:0] = 32'h4000_0000;
        @(negedge clk);
        check("lat4_ready", r4_ready, 2'b01);
        tick();
        r4_valid = 2'b00;
        n = 1;
        @(negedge clk);
        while (!r4_rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("lat4_latency", n, 5);
        check("lat4_rsp", {r4_rsp_id, r4_rsp_ovf, r4_rsp_y}, {1'b0, 1'b0, 32'h4000_0000});
        tick();

        // Reset two cycles after accepting an overflowing op (LAT=4)
        tick();
        r4_valid = 2'b01; r4_x1[31:0] = 32'h7F00_0000; r4_x2[31:0] = 32'h4000_0000;
        @(negedge clk);
        check("midrst_accept", r4_ready, 2'b01);
        tick();
        r4_valid = 2'b00;
        tick();
        r4_rst = 1'b1;
        tick();
        r4_rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", r4_ready, 2'b01);
        check("midrst_busy", r4_busy, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            check("midrst_no_rsp", r4_rsp_valid, 1'b0);
        end
        check("midrst_sticky", r4_sticky, 2'b00);

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
